// File: rtl/gf128_koa_mul_iter.sv
// Iterative Karatsuba carry-less multiplier feeding the GF(2^128) reduction stage.
// Latency: 5 edges from accept to out_valid (one shared HALFxHALF multiplier, three passes); holds product in DONE until out_ready.
module gf128_koa_mul_iter #(
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_product,
    output logic                  busy
);
    localparam int HALF = DATA_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL_HI,
        MUL_LO,
        MUL_MID,
        COMBINE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [DATA_W-1:0]     h_q, h_d;
    logic [DATA_W-1:0]     l_q, l_d;
    logic [DATA_W-1:0]     m_q, m_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;
    logic [HALF-1:0]       mul_x, mul_y;
    logic [DATA_W-1:0]     mul_r;

    function automatic logic [DATA_W-1:0] clmul_half(input logic [HALF-1:0] x,
                                                     input logic [HALF-1:0] y);
        logic [DATA_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < HALF; i++) begin
            if (y[i]) acc = acc ^ ({{HALF{1'b0}}, x} << i);
        end
        return acc;
    endfunction

    // One combinational multiplier, operands steered by the current pass.
    always_comb begin
        mul_x = a_q[DATA_W-1:HALF];
        mul_y = b_q[DATA_W-1:HALF];
        case (state_q)
            MUL_LO: begin
                mul_x = a_q[HALF-1:0];
                mul_y = b_q[HALF-1:0];
            end
            MUL_MID: begin
                mul_x = a_q[DATA_W-1:HALF] ^ a_q[HALF-1:0];
                mul_y = b_q[DATA_W-1:HALF] ^ b_q[HALF-1:0];
            end
            default: ;
        endcase
    end

    assign mul_r = clmul_half(mul_x, mul_y);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        h_d       = h_q;
        l_d       = l_q;
        m_d       = m_q;
        prod_d    = prod_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = MUL_HI;
                end
            end
            MUL_HI: begin
                h_d     = mul_r;
                state_d = MUL_LO;
            end
            MUL_LO: begin
                l_d     = mul_r;
                state_d = MUL_MID;
            end
            MUL_MID: begin
                m_d     = mul_r;
                state_d = COMBINE;
            end
            COMBINE: begin
                prod_d  = {h_q, {DATA_W{1'b0}}}
                        ^ {{HALF{1'b0}}, m_q ^ h_q ^ l_q, {HALF{1'b0}}}
                        ^ {{DATA_W{1'b0}}, l_q};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
            m_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            h_q     <= h_d;
            l_q     <= l_d;
            m_q     <= m_d;
            prod_q  <= prod_d;
        end
    end

    assign out_product = prod_q;

endmodule

// File: tb/tb_gf128_koa_mul_iter.sv
// Bench for gf128_koa_mul_iter: directed corner products plus randomized traffic against a bit-serial carry-less model.
module tb_gf128_koa_mul_iter;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_a;
    logic [127:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_product;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    gf128_koa_mul_iter #(.DATA_W(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Schoolbook carry-less product over the full operand width.
    function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) r = r ^ ({128'b0, a} << i);
        end
        return r;
    endfunction

    logic [255:0] exp_q[$];
    bit           prev_vld;
    bit           prev_rdy;
    logic [255:0] prev_prod;
    int           lat_target;
    bit           lat_pend;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
            lat_pend = 1'b0;
            chk(out_valid == 1'b0, "rst_out_valid", 256'(out_valid), 256'(0));
            chk(in_ready == 1'b1, "rst_in_ready", 256'(in_ready), 256'(1));
            chk(busy == 1'b0, "rst_busy", 256'(busy), 256'(0));
            chk(out_product == '0, "rst_out_product", out_product, 256'(0));
        end else begin
            chk(busy == !in_ready, "busy_vs_ready", 256'(busy), 256'(!in_ready));
            if (exp_q.size() != 0)
                chk(in_ready == 1'b0, "in_ready_while_busy", 256'(in_ready), 256'(0));
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(in_a, in_b));
                lat_target = cyc + 5;
                lat_pend   = 1'b1;
            end
            if (out_valid) begin
                if (!prev_vld && lat_pend) begin
                    chk(cyc == lat_target, "latency", 256'(cyc), 256'(lat_target));
                    lat_pend = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_out_valid", out_product, 256'(0));
                end else begin
                    chk(out_product == exp_q[0], "model_product", out_product, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (prev_vld && !prev_rdy)
                    chk(out_product == prev_prod, "hold_stable", out_product, prev_prod);
            end else if (prev_vld && !prev_rdy) begin
                chk(1'b0, "valid_dropped", 256'(out_valid), 256'(1));
            end
            prev_vld  = out_valid;
            prev_rdy  = out_ready;
            prev_prod = out_product;
        end
    end

    task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic [255:0] expv,
                         input bit lit, input int hold, input bit rnd,
                         input logic [127:0] na, input logic [127:0] nb, input bit pre,
                         input string nm);
        int n;
        int h;
        logic [255:0] snap;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk(1'b0, "accept_timeout", 256'(in_ready), 256'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = pre;
        in_a     = na;
        in_b     = nb;
        chk(in_ready == 1'b0, "in_ready_drop", 256'(in_ready), 256'(0));
        n = 0;
        while (!out_valid && n < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            chk(1'b0, "out_valid_timeout", 256'(out_valid), 256'(1));
            return;
        end
        h = rnd ? int'($urandom_range(0, 3)) : hold;
        if (h > 0) begin
            out_ready = 1'b0;
            snap = out_product;
            repeat (h) begin
                @(posedge clk); #1;
                chk(out_valid == 1'b1, "bp_valid_held", 256'(out_valid), 256'(1));
                chk(out_product == snap, "bp_product_stable", out_product, snap);
                chk(in_ready == 1'b0, "bp_in_ready_low", 256'(in_ready), 256'(0));
            end
        end
        out_ready = 1'b1;
        if (lit) chk(out_product == expv, nm, out_product, expv);
        @(posedge clk); #1;
        chk(in_ready == 1'b1, "post_hs_in_ready", 256'(in_ready), 256'(1));
        chk(busy == 1'b0, "post_hs_busy", 256'(busy), 256'(0));
    endtask

    initial begin
        logic [255:0] e;
        logic [127:0] a;
        logic [127:0] ca, cb, na, nb;
        bit           pre;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        e = 256'h1;
        do_op(128'h1, 128'h1, e, 1, 0, 0, ~128'h1, ~128'h1, 0, "one_x_one");
        e = 256'h5;
        do_op(128'h3, 128'h3, e, 1, 0, 0, ~128'h3, ~128'h3, 0, "three_x_three");
        a = 128'h1 << 64;
        e = 256'h1 << 128;
        do_op(a, a, e, 1, 0, 0, ~a, ~a, 0, "x64_squared");
        a = 128'h1 << 127;
        e = 256'h1 << 254;
        do_op(a, a, e, 1, 0, 0, ~a, ~a, 0, "x127_squared");
        a = '1;
        e = {128'h0, a};
        do_op(a, 128'h1, e, 1, 0, 0, 128'h0, 128'h0, 0, "ones_x_one");
        a = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        do_op(a, 128'h3, ref_mul(a, 128'h3), 1, 10, 0, ~a, 128'h0, 0, "backpressure");

        // Abort an operation in MUL_MID; in_valid asserted during reset must be ignored.
        in_a     = 128'hDEADBEEF;
        in_b     = 128'h12345;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 128'h9;
        in_b     = 128'h9;
        #1;
        chk(out_valid == 1'b0, "midrst_out_valid", 256'(out_valid), 256'(0));
        chk(in_ready == 1'b1, "midrst_in_ready", 256'(in_ready), 256'(1));
        chk(busy == 1'b0, "midrst_busy", 256'(busy), 256'(0));
        chk(out_product == '0, "midrst_out_product", out_product, 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        e = 256'h1B;
        do_op(128'h5, 128'h7, e, 1, 0, 0, 128'h0, 128'h0, 0, "five_x_seven");

        na = {$urandom, $urandom, $urandom, $urandom};
        nb = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 1000; i++) begin
            ca = na;
            cb = nb;
            na = {$urandom, $urandom, $urandom, $urandom};
            nb = {$urandom, $urandom, $urandom, $urandom};
            if (i % 97 == 0) na = '1;
            if (i % 131 == 0) nb = '0;
            pre = 1'($urandom_range(0, 1));
            do_op(ca, cb, 256'(0), 0, 0, 1, na, nb, pre, "random");
            if (!pre) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "no_lost_results", 256'(exp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gf128_koa_mul_iter.md
Name: gf128_koa_mul_iter

Overview:
Iterative carry-less Karatsuba multiplier that sits directly upstream of the GF(2^128) modular reduction stage. It takes two DATA_W-bit polynomials and produces their full 2*DATA_W-bit carry-less product for the reduction stage to consume. The block reuses one combinational HALF x HALF carry-less multiplier (HALF = DATA_W/2) over three cycles for the KOA partial products, then combines them. It uses valid/ready handshakes on both sides.

Parameters:
DATA_W, 128, operand width in bits; must be even; HALF = DATA_W/2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  DATA_W  operand A; bit i = coefficient of x^i
in_b  input  DATA_W  operand B; same bit ordering
out_valid  output  1  out_product valid
out_ready  input  1  downstream (reduction stage) accepts product
out_product  output  2*DATA_W  carry-less product A*B; bit i = coefficient of x^i
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous, active-high, with synchronous deassertion handled at SoC level. State goes to IDLE. in_ready=1, out_valid=0, busy=0, out_product=0, and all internal partial-product and operand registers are cleared.
- Split: A = A1*x^HALF + A0 and B = B1*x^HALF + B0.
  - H = A1*B1, L = A0*B0, M = (A1^A0)*(B1^B0). All products are carry-less, each 2*HALF-1 bits, zero-extended to DATA_W.
- Product: P = (H << DATA_W) ^ ((M ^ H ^ L) << HALF) ^ L, truncated to 2*DATA_W bits. Bit 2*DATA_W-1 is always 0.
- Bit ordering is plain polynomial order. The block performs no bit reflection; the reduction stage owns the GCM convention.
- FSM states: IDLE -> MUL_HI -> MUL_LO -> MUL_MID -> COMBINE -> DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_a/in_b and move to MUL_HI. Operands are sampled only at this edge.
  - MUL_HI: shared multiplier fed A1,B1; H registered; go to MUL_LO.
  - MUL_LO: fed A0,B0; L registered; go to MUL_MID.
  - MUL_MID: fed A1^A0, B1^B0; M registered; go to COMBINE.
  - COMBINE: P computed and registered into out_product; go to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready, go to IDLE. Otherwise stay in DONE and hold out_product stable.
- Latency: out_valid rises on the 5th rising edge after the accept edge (accept edge plus 4 state edges). The acceptance-to-output pipeline has fixed latency and no bubbles.
- Throughput: one product per 6 cycles when out_ready is held high. in_ready=1 only in IDLE, so the block never accepts during DONE, including the cycle in which the output handshake completes.
- Operand inputs are don't-care outside IDLE. Changes to in_a/in_b after acceptance must not affect the result.
- out_product holds its last value after the handshake until the next COMBINE, but it is only meaningful while out_valid=1.
- out_valid must not drop without a handshake. out_product must not change while out_valid=1 and out_ready=0.
- Reset mid-operation, in any state: the in-flight operation is discarded. The block returns to the reset values, and no out_valid pulse appears for the discarded operands.
- in_valid=1 during rst: ignored; no accept occurs while rst is high.
- The shared HALF x HALF carry-less multiplier is a combinational function or submodule inside this block: XOR of shifted partial products, with no pipeline registers.

Test Plan:
1. Reset, then A=1, B=1 with out_ready=1 -> in_ready drops the cycle after accept. out_valid rises 5 edges after accept, out_product=256'h1, busy falls after the handshake.
2. A=128'h3, B=128'h3 -> 256'h5 (x^2+1). A=128'h1<<64, B=128'h1<<64 -> out_product has only bit 128 set. Back-to-back pairs are accepted only when in_ready=1.
3. A=128'h8000...0 (bit 127), B=same -> only bit 254 set. A=all-ones, B=1 -> out_product[127:0]=all-ones and upper half zero.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, out_product is stable, in_ready=0 throughout. Raising out_ready completes the handshake, and in_ready=1 on the next cycle.
5. Reset mid-operation: assert rst in MUL_MID -> outputs return to reset values immediately, and no out_valid is seen. A fresh A=5, B=7 then yields 256'h1B.
6. Randomized: 1000 random A/B pairs with random out_ready and in_valid gaps -> every product matches a bit-serial carry-less reference model, with no lost or duplicated results.
